// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller family.
package elevator_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Bits needed to index n floors (or hold 0..n-1), never less than one.
  function automatic int floor_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/elevator_req_scan.sv
// Splits a request vector around the car position into above / below / here flags.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 5,
  parameter int FLOOR_W    = floor_w(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] i_req_vec,
  input  logic [FLOOR_W-1:0]    i_cur,
  output logic                  o_above,
  output logic                  o_below,
  output logic                  o_here
);
  always_comb begin
    o_above = 1'b0;
    o_below = 1'b0;
    o_here  = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (FLOOR_W'(f) > i_cur)  o_above = o_above | i_req_vec[f];
      if (FLOOR_W'(f) < i_cur)  o_below = o_below | i_req_vec[f];
      if (FLOOR_W'(f) == i_cur) o_here  = i_req_vec[f];
    end
  end
endmodule

// File: rtl/elevator_controller_n.sv
// Single-car, N-floor SCAN elevator controller with door dwell and travel timers.
module elevator_controller_n
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS       = 5,
  parameter int DOOR_OPEN_CYCLES = 3,
  parameter int TRAVEL_CYCLES    = 4,
  localparam int FLOOR_W         = floor_w(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] buttons,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  door_open,
  output logic                  moving,
  output logic                  direction,
  output logic [NUM_FLOORS-1:0] pending_reqs
);
  localparam int CNT_MAX = (DOOR_OPEN_CYCLES > TRAVEL_CYCLES) ? DOOR_OPEN_CYCLES : TRAVEL_CYCLES;
  localparam int CNT_W   = floor_w(CNT_MAX);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);

  state_t                  r_state, w_state;
  logic [FLOOR_W-1:0]      r_cur, w_cur, w_nf;
  logic                    r_dir, w_dir, r_door, w_door, r_moving, w_moving;
  logic [NUM_FLOORS-1:0]   r_pend, w_pend, w_req, w_mask_cur, w_mask_nf;
  logic [CNT_W-1:0]        r_dwell, w_dwell, r_travel, w_travel;
  logic                    w_above, w_below, w_here, w_req_nf, w_ahead, w_behind;

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan (
    .i_req_vec (w_req),
    .i_cur     (r_cur),
    .o_above   (w_above),
    .o_below   (w_below),
    .o_here    (w_here)
  );

  // A press is acted on at the same edge it is seen, so decisions use pending | buttons.
  always_comb begin
    w_req = r_pend | buttons;
    w_nf  = r_dir ? r_cur + 1'b1 : r_cur - 1'b1;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      w_mask_cur[f] = (FLOOR_W'(f) == r_cur);
      w_mask_nf[f]  = (FLOOR_W'(f) == w_nf);
    end
    w_req_nf = |(w_req & w_mask_nf);
    w_ahead  = r_dir ? w_above : w_below;
    w_behind = r_dir ? w_below : w_above;
  end

  always_comb begin
    w_state  = r_state;
    w_cur    = r_cur;
    w_dir    = r_dir;
    w_door   = 1'b0;
    w_moving = 1'b0;
    w_pend   = w_req;
    w_dwell  = r_dwell;
    w_travel = r_travel;
    case (r_state)
      IDLE: begin
        if (w_here) begin
          w_state = DOOR_OPEN;
          w_door  = 1'b1;
          w_dwell = DWELL_LD;
          w_pend  = w_req & ~w_mask_cur;
        end else if ((r_dir & w_above) | (w_above & ~w_below)) begin
          w_dir    = UP;
          w_state  = MOVING;
          w_moving = 1'b1;
          w_travel = TRAVEL_LD;
        end else if (w_below) begin
          w_dir    = DOWN;
          w_state  = MOVING;
          w_moving = 1'b1;
          w_travel = TRAVEL_LD;
        end
      end
      MOVING: begin
        w_moving = 1'b1;
        if (r_travel == '0) begin
          w_cur = w_nf;
          if (w_req_nf) begin
            w_moving = 1'b0;
            w_door   = 1'b1;
            w_state  = DOOR_OPEN;
            w_dwell  = DWELL_LD;
            w_pend   = w_req & ~w_mask_nf;
          end else begin
            w_travel = TRAVEL_LD;
          end
        end else begin
          w_travel = r_travel - 1'b1;
        end
      end
      DOOR_OPEN: begin
        w_door = 1'b1;
        w_pend = w_req & ~w_mask_cur;
        // A press of this floor while open extends the dwell instead of queueing a revisit.
        if (w_here) begin
          w_dwell = DWELL_LD;
        end else if (r_dwell != '0) begin
          w_dwell = r_dwell - 1'b1;
        end else begin
          w_door = 1'b0;
          if (w_ahead | w_behind) begin
            w_dir    = w_ahead ? r_dir : ~r_dir;
            w_state  = MOVING;
            w_moving = 1'b1;
            w_travel = TRAVEL_LD;
          end else begin
            w_state = IDLE;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cur    <= '0;
      r_dir    <= UP;
      r_door   <= 1'b0;
      r_moving <= 1'b0;
      r_pend   <= '0;
      r_dwell  <= '0;
      r_travel <= '0;
    end else begin
      r_state  <= w_state;
      r_cur    <= w_cur;
      r_dir    <= w_dir;
      r_door   <= w_door;
      r_moving <= w_moving;
      r_pend   <= w_pend;
      r_dwell  <= w_dwell;
      r_travel <= w_travel;
    end
  end

  assign current_floor = r_cur;
  assign door_open     = r_door;
  assign moving        = r_moving;
  assign direction     = r_dir;
  assign pending_reqs  = r_pend;
endmodule

// File: tb/tb_elevator_controller_n.sv
// Scoreboard bench: expected stop floors are queued as calls are made, popped on each door opening.
module tb_elevator_controller_n;
  localparam int NF = 5;
  localparam int DC = 3;
  localparam int TC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] buttons;
  logic [2:0]    current_floor;
  logic          door_open, moving, direction;
  logic [NF-1:0] pending_reqs;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  logic prev_door = 1'b0;

  elevator_controller_n #(.NUM_FLOORS(NF), .DOOR_OPEN_CYCLES(DC), .TRAVEL_CYCLES(TC)) dut (
    .clk           (clk),
    .rst           (rst),
    .buttons       (buttons),
    .current_floor (current_floor),
    .door_open     (door_open),
    .moving        (moving),
    .direction     (direction),
    .pending_reqs  (pending_reqs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Invariants every cycle plus scoreboard pop on each door opening.
  always @(negedge clk) begin
    if (!rst) begin
      chk("excl", int'(door_open & moving), 0);
      chk("range", int'(current_floor < NF), 1);
      if (door_open && !prev_door) begin
        if (exp_q.size() == 0) chk("stop_extra", int'(current_floor), -1);
        else                   chk("stop", int'(current_floor), exp_q.pop_front());
      end
    end
    prev_door = door_open;
  end

  task automatic pulse(input logic [NF-1:0] b);
    buttons = b;
    @(negedge clk);
    buttons = '0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while ((door_open || moving || exp_q.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk(tag, int'(g < 300), 1);
  endtask

  initial begin
    int g, n, steps;
    logic [2:0] pf;
    rst = 1'b1;
    buttons = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_floor", int'(current_floor), 0);
    chk("rst_dir", int'(direction), 1);
    chk("rst_pend", int'(pending_reqs), 0);

    // Reset mid-move at floor 2
    pulse(5'b10000);
    g = 0;
    while (current_floor != 3'd2 && g < 40) begin @(negedge clk); g++; end
    chk("reach2", int'(current_floor), 2);
    chk("mid_move", int'(moving), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rr_floor", int'(current_floor), 0);
    chk("rr_door", int'(door_open), 0);
    chk("rr_moving", int'(moving), 0);
    chk("rr_dir", int'(direction), 1);
    chk("rr_pend", int'(pending_reqs), 0);

    // Press at idle floor 0: door opens same edge for exactly DC cycles
    exp_q.push_back(0);
    pulse(5'b00001);
    chk("here_door", int'(door_open), 1);
    chk("here_pend", int'(pending_reqs), 0);
    n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (door_open) n++;
      chk("here_pend_dwell", int'(pending_reqs), 0);
    end
    chk("dwell_len", n, DC);
    chk("here_idle", int'(moving), 0);

    // Travel 0 -> 3, one floor per TC cycles
    exp_q.push_back(3);
    pulse(5'b01000);
    chk("trav_moving", int'(moving), 1);
    for (int k = 1; k < 13; k++) begin
      @(negedge clk);
      chk("trav_floor", int'(current_floor), k / TC);
    end
    chk("arr_door", int'(door_open), 1);
    chk("arr_pend", int'(pending_reqs), 0);
    wait_idle("idle3");

    // From floor 0 heading to 4, at floor 2 call 1 and 3: stops 3, 4, 1
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    pulse(5'b10000);
    g = 0;
    while (current_floor != 3'd2 && g < 40) begin @(negedge clk); g++; end
    chk("sweep_at2", int'(current_floor), 2);
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(1);
    pulse(5'b01010);
    wait_idle("idle_sweep");
    chk("sweep_end", int'(current_floor), 1);
    chk("sweep_dir", int'(direction), 0);

    // Go to top, then call floor 0: reverse and make four steps down
    exp_q.push_back(4);
    pulse(5'b10000);
    wait_idle("idle_top");
    chk("top_floor", int'(current_floor), 4);
    chk("top_dir", int'(direction), 1);
    exp_q.push_back(0);
    pulse(5'b00001);
    chk("rev_dir", int'(direction), 0);
    chk("rev_moving", int'(moving), 1);
    steps = 0; g = 0; pf = current_floor;
    while (!door_open && g < 60) begin
      @(negedge clk);
      if (current_floor != pf) steps++;
      pf = current_floor;
      g++;
    end
    chk("rev_steps", steps, 4);
    wait_idle("idle_bot");

    // Door open at floor 1, hold its button 5 cycles
    exp_q.push_back(1);
    pulse(5'b00010);
    g = 0;
    while (!door_open && g < 40) begin @(negedge clk); g++; end
    chk("hold_open", int'(door_open), 1);
    buttons = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_door", int'(door_open), 1);
      chk("hold_pend1", int'(pending_reqs[1]), 0);
    end
    buttons = '0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!door_open) break;
      n++;
    end
    chk("hold_tail", n, DC - 1);
    wait_idle("idle_end");
    chk("q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
